// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit von Neumann CPU (req/ack memory handshake).
// Optional build macro: CPU_CTRL_SINGLE_STEP_EN adds a 'step' input gating each instruction fetch.
module cpu_ctrl_fsm #(
   parameter int OPC_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] ir_opcode,
   input  logic             ac_zero,
   input  logic             mem_ack,
`ifdef CPU_CTRL_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic             mem_req,
   output logic             mem_we,
   output logic             mar_sel,
   output logic             mar_load,
   output logic             ir_load,
   output logic             pc_load,
   output logic             pc_inc,
   output logic             pc_clear,
   output logic             ac_load,
   output logic             ac_clear,
   output logic [1:0]       alu_op,
   output logic             halted,
   output logic [7:0]       instr_count
);

   typedef enum logic [2:0] {
      S_RST, S_CLR, S_FETCH, S_FREQ, S_DECODE, S_EREQ, S_HALT
   } state_t;

   localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
   localparam logic [OPC_W-1:0] OP_LDA = 3'd1;
   localparam logic [OPC_W-1:0] OP_STA = 3'd2;
   localparam logic [OPC_W-1:0] OP_ADD = 3'd3;
   localparam logic [OPC_W-1:0] OP_SUB = 3'd4;
   localparam logic [OPC_W-1:0] OP_JMP = 3'd5;
   localparam logic [OPC_W-1:0] OP_JZ  = 3'd6;
   localparam logic [OPC_W-1:0] OP_CLA = 3'd7;

   state_t state, state_nxt;
   logic   retire;
   logic   fetch_go;

`ifdef CPU_CTRL_SINGLE_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RST;
         instr_count <= 8'd0;
      end else begin
         state <= state_nxt;
         if (retire) instr_count <= instr_count + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mar_sel   = 1'b0;
      mar_load  = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_clear  = 1'b0;
      ac_load   = 1'b0;
      ac_clear  = 1'b0;
      alu_op    = 2'b00;
      halted    = 1'b0;
      case (state)
         S_RST: state_nxt = S_CLR;
         S_CLR: begin
            pc_clear  = 1'b1;
            ac_clear  = 1'b1;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (fetch_go) begin
               mar_load  = 1'b1;
               state_nxt = S_FREQ;
            end
         end
         S_FREQ: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_load   = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_opcode)
               OP_HLT: begin
                  retire    = 1'b1;
                  state_nxt = S_HALT;
               end
               OP_CLA: begin
                  ac_clear  = 1'b1;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               OP_JMP: begin
                  pc_load   = 1'b1;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               OP_JZ: begin
                  pc_load   = ac_zero;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end
               default: begin
                  // LDA/STA/ADD/SUB: operand address comes from IR[4:0]
                  mar_sel   = 1'b1;
                  mar_load  = 1'b1;
                  state_nxt = S_EREQ;
               end
            endcase
         end
         S_EREQ: begin
            mem_req = 1'b1;
            mem_we  = (ir_opcode == OP_STA);
            if (mem_ack) begin
               case (ir_opcode)
                  OP_LDA: begin ac_load = 1'b1; alu_op = 2'b00; end
                  OP_ADD: begin ac_load = 1'b1; alu_op = 2'b01; end
                  OP_SUB: begin ac_load = 1'b1; alu_op = 2'b10; end
                  default: ;
               endcase
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_HALT: halted = 1'b1;
         default: state_nxt = S_RST;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: small datapath + memory model around the sequencer, scoreboard of expected results.
module tb_cpu_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] ir_opcode;
   logic       ac_zero, mem_ack;
   logic       mem_req, mem_we, mar_sel, mar_load, ir_load;
   logic       pc_load, pc_inc, pc_clear, ac_load, ac_clear, halted;
   logic [1:0] alu_op;
   logic [7:0] instr_count;
`ifdef CPU_CTRL_SINGLE_STEP_EN
   logic       step = 1'b1;
`endif

   always #5 clk = ~clk;

   cpu_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ac_zero(ac_zero), .mem_ack(mem_ack),
`ifdef CPU_CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .mem_req(mem_req), .mem_we(mem_we), .mar_sel(mar_sel), .mar_load(mar_load),
      .ir_load(ir_load), .pc_load(pc_load), .pc_inc(pc_inc), .pc_clear(pc_clear),
      .ac_load(ac_load), .ac_clear(ac_clear), .alu_op(alu_op), .halted(halted),
      .instr_count(instr_count)
   );

   // Datapath and memory model
   logic [7:0] pc = 8'd0, ir = 8'd0, mar = 8'd0, ac = 8'd0;
   logic [7:0] mem [256];
   int         ack_dly = 0;
   logic       ack_force = 1'b0;
   int         wcnt = 0;
   int         nwrites = 0;
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = 8'd0, ld_data = 8'd0;
   logic [12:0] outv;

   assign ir_opcode = ir[7:5];
   assign ac_zero   = (ac == 8'h00);
   assign mem_ack   = ack_force | (mem_req && (wcnt >= ack_dly));
   assign outv = {mem_req, mem_we, mar_sel, mar_load, ir_load, pc_load, pc_inc, pc_clear,
                  ac_load, ac_clear, alu_op, halted};

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (mem_req && mem_we && mem_ack) begin
         mem[mar] <= ac;
         nwrites  <= nwrites + 1;
      end
      if (!mem_req || mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (pc_clear) pc <= 8'd0;
      else if (pc_load) pc <= {3'b000, ir[4:0]};
      else if (pc_inc) pc <= pc + 8'd1;
      if (mar_load) mar <= mar_sel ? {3'b000, ir[4:0]} : pc;
      if (ir_load) ir <= mem[mar];
      if (ac_clear) ac <= 8'd0;
      else if (ac_load) begin
         case (alu_op)
            2'b00:   ac <= mem[mar];
            2'b01:   ac <= ac + mem[mar];
            2'b10:   ac <= ac - mem[mar];
            default: ac <= ac;
         endcase
      end
   end

   int errors = 0;
   int checks = 0;
   string       tq[$];
   logic [31:0] vq[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      tq.push_back(tag);
      vq.push_back(v);
   endtask

   task automatic pop(input logic [31:0] act);
      if (tq.size() == 0) chk("sb_empty", 0, 1);
      else chk(tq.pop_front(), act, vq.pop_front());
   endtask

   // Per-cycle handshake stability and strobe exclusion
   logic pend = 1'b0, pend_we = 1'b0, pcl_seen = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) pend = 1'b0;
      else begin
         if (pend) begin
            chk("req_hold", mem_req, 1);
            chk("we_hold", mem_we, pend_we);
         end
         pend    = mem_req && !mem_ack;
         pend_we = mem_we;
         chk("pc_mutex", ($countones({pc_load, pc_inc, pc_clear}) <= 1), 1);
         chk("ac_mutex", ($countones({ac_load, ac_clear}) <= 1), 1);
         if (pc_clear) pcl_seen = 1'b0;
         else if (pc_load) pcl_seen = 1'b1;
      end
   end

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ld_addr = a; ld_data = d; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic prep(input bit clear);
      @(negedge clk); #1;
      rst_n = 1'b0;
      if (clear) for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
   endtask

   task automatic start();
      int n;
      @(negedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      while (!pc_clear && n < 10) begin @(negedge clk); n++; end
      chk("clr_wait", pc_clear, 1);
   endtask

   task automatic run_to_halt(input int max, output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!halted && cyc < max);
      chk("halt_wait", halted, 1);
      cyc = cyc - 1;
   endtask

   task automatic prog_add(input int dly);
      int cyc;
      prep(1);
      poke(0, 8'h25); poke(1, 8'h66); poke(2, 8'h47); poke(3, 8'h00);
      poke(5, 8'h03); poke(6, 8'h04);
      ack_dly = dly;
      push("add_m7", 8'h07); push("add_cnt", 4); push("add_cyc", 15 + 7 * dly);
      start();
      run_to_halt(200, cyc);
      pop(mem[7]); pop(instr_count); pop(cyc);
   endtask

   task automatic prog_jz(input bit zero);
      int cyc;
      prep(1);
      poke(0, zero ? 8'hE0 : 8'h34); poke(1, 8'hCA); poke(2, 8'h00);
      poke(10, 8'h00); poke(20, 8'h01);
      ack_dly = 0;
      push("jz_pc", zero ? 11 : 3); push("jz_cnt", 3); push("jz_pcload", zero);
      start();
      run_to_halt(200, cyc);
      pop(pc); pop(instr_count); pop(pcl_seen);
   endtask

   initial begin
      int cyc, n, w0;
      // Reset state and the first cycles after release (all memory = HLT)
      ack_dly = 0;
      prep(1);
      push("rst_out", 0); push("rst_cnt", 0);
      @(negedge clk);
      pop(outv); pop(instr_count);
      push("clr_out", 13'h028); push("clr_cnt", 0); push("fetch_out", 13'h200);
      push("freq_out", 13'h1140); push("dec_out", 0); push("halt_out", 13'h001); push("halt_cnt", 1);
      #1 rst_n = 1'b1;
      @(negedge clk); pop(outv); pop(instr_count);
      @(negedge clk); pop(outv);
      @(negedge clk); pop(outv);
      @(negedge clk); pop(outv);
      @(negedge clk); pop(outv); pop(instr_count);

      prog_add(0);
      prog_add(3);
      prog_jz(1'b1);
      prog_jz(1'b0);

      // 256 retirements wrap the counter; ack held high throughout
      prep(0);
      for (int i = 0; i < 255; i++) poke(8'(i), 8'hE0);
      poke(8'd255, 8'h00);
      ack_force = 1'b1;
      push("wrap_cnt", 0); push("wrap_cyc", 768); push("wrap_pc", 0);
      start();
      run_to_halt(2000, cyc);
      pop(instr_count); pop(cyc); pop(pc);
      ack_force = 1'b0;

      // Reset while STA is waiting for its write ack
      prep(1);
      poke(0, 8'h25); poke(1, 8'h47); poke(2, 8'h00); poke(5, 8'h03); poke(7, 8'hAA);
      ack_dly = 3;
      start();
      n = 0;
      while (!mem_we && n < 50) begin @(negedge clk); n++; end
      chk("sta_wait", mem_we, 1);
      w0 = nwrites;
      push("rst_req", 0); push("rst_m7", 8'hAA); push("rst_nwr", w0);
      #2 rst_n = 1'b0;
      #1 pop(mem_req);
      @(negedge clk); @(negedge clk);
      pop(mem[7]); pop(nwrites);
      ack_dly = 0;
      push("rerun_m7", 8'h03); push("rerun_cnt", 3);
      start();
      run_to_halt(200, cyc);
      pop(mem[7]); pop(instr_count);

`ifdef CPU_CTRL_SINGLE_STEP_EN
      prep(1);
      for (int i = 0; i < 4; i++) poke(8'(i), 8'hE0);
      step = 1'b0;
      push("ss_idle_cnt", 0); push("ss_idle_out", 0); push("ss_one_cnt", 1); push("ss_run_cnt", 5);
      start();
      repeat (8) @(negedge clk);
      pop(instr_count); pop(outv);
      #1 step = 1'b1;
      @(negedge clk); #1 step = 1'b0;
      repeat (8) @(negedge clk);
      pop(instr_count);
      #1 step = 1'b1;
      run_to_halt(200, cyc);
      pop(instr_count);
`endif

      chk("sb_drained", tq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
